rom_dl_packer: RTL and testbench

- Receives the HPS 16-bit ioctl download stream and packs halfword pairs into 32-bit Wishbone write cycles to SDRAM.
- A small word FIFO sits between the packer and the Wishbone master, so HPS stalls only when the FIFO is nearly full.
- Sits between hps_io and the SDRAM arbiter mux. While `active` is high, the top level routes the SDRAM Wishbone port to this block.

---
 rtl/rom_dl_packer.sv | 188 ++++++++++++++++++
 tb/tb_rom_dl_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_packer.sv
// Packs the 16-bit HPS ioctl download stream into 32-bit Wishbone writes to SDRAM,
// decoupled from the slave by a small dual-push word FIFO.
module rom_dl_packer #(
  parameter logic [7:0]  INDEX = 8'd1,
  parameter logic [25:0] BASE  = 26'h0400000,
  parameter int          DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [25:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic [2:0]  wb_cti,
  input  logic        wb_ack,
  output logic        active,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [23:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } entry_t;

  function automatic logic [23:0] word_adr(input logic [22:0] pa);
    logic [25:0] sum;
    sum = BASE + {1'b0, pa, 2'b00};
    return sum[25:2];
  endfunction

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [22:0]   pa_q, pa_d;
  logic [15:0]   lo_q, lo_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          cyc_q;
  logic [25:0]   adr_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;
  entry_t        mem_q [DEPTH];

  logic          dl_sel, wr_ok, push0, push1, pop;
  logic [1:0]    n_push;
  entry_t        e0, e1, pend_entry;

  assign dl_sel = ioctl_download && (ioctl_index == INDEX);
  // Writes are taken only while loading; the IDLE cycle covers a strobe coincident with sel rising.
  assign wr_ok  = ioctl_wr && dl_sel && (state_q == S_IDLE || state_q == S_LOAD);
  assign pop    = cyc_q && wb_ack;
  assign n_push = {1'b0, push0} + {1'b0, push1};
  assign pend_entry = entry_t'{word_adr(pa_q), 4'b0011, {16'h0, lo_q}};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    push0  = 1'b0;
    push1  = 1'b0;
    e0     = '0;
    e1     = '0;
    pend_d = pend_q;
    pa_d   = pa_q;
    lo_d   = lo_q;
    if (state_q == S_FLUSH) begin
      if (pend_q) begin
        push0  = 1'b1;
        e0     = pend_entry;
        pend_d = 1'b0;
      end
    end else if (wr_ok) begin
      if (!ioctl_addr[1]) begin
        if (pend_q) begin
          push0 = 1'b1;
          e0    = pend_entry;
        end
        pend_d = 1'b1;
        pa_d   = ioctl_addr[24:2];
        lo_d   = ioctl_dout;
      end else if (pend_q && pa_q == ioctl_addr[24:2]) begin
        push0  = 1'b1;
        e0     = entry_t'{word_adr(pa_q), 4'b1111, {ioctl_dout, lo_q}};
        pend_d = 1'b0;
      end else if (pend_q) begin
        push0  = 1'b1;
        e0     = pend_entry;
        push1  = 1'b1;
        e1     = entry_t'{word_adr(ioctl_addr[24:2]), 4'b1100, {ioctl_dout, 16'h0}};
        pend_d = 1'b0;
      end else begin
        push0  = 1'b1;
        e0     = entry_t'{word_adr(ioctl_addr[24:2]), 4'b1100, {ioctl_dout, 16'h0}};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q + AW'(n_push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(n_push) - CW'(pop);
    case (state_q)
      S_IDLE:  if (dl_sel) state_d = S_LOAD;
      S_LOAD:  if (!dl_sel) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0 && !cyc_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      pa_q     <= '0;
      lo_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pa_q     <= pa_d;
      lo_q     <= lo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_sys) begin
    if (push0) mem_q[wr_ptr_q] <= e0;
    if (push1) mem_q[wr_ptr_q + AW'(1)] <= e1;
  end

  // Wishbone master: load the head when idle, hold until ack, drop on the edge after ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= 1'b0;
      adr_q <= '0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (cyc_q) begin
      if (wb_ack) cyc_q <= 1'b0;
    end else if (count_q != '0) begin
      cyc_q <= 1'b1;
      adr_q <= {mem_q[rd_ptr_q].adr, 2'b00};
      sel_q <= mem_q[rd_ptr_q].sel;
      dat_q <= mem_q[rd_ptr_q].dat;
    end
  end

  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_we      = cyc_q;
  assign wb_adr     = adr_q;
  assign wb_sel     = sel_q;
  assign wb_dat_o   = dat_q;
  assign wb_cti     = 3'b000;
  assign active     = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign ioctl_wait = (count_q >= CW'(DEPTH - 2)) ||
                      (state_q == S_FLUSH) || (state_q == S_DRAIN) || (state_q == S_DONE);

`ifndef SYNTHESIS
  logic ovf;
  assign ovf = (int'(count_q) + int'(n_push) - int'(pop)) > DEPTH;
  always_ff @(posedge clk_sys) begin
    if (reset_n) assert (!ovf);
  end
`endif

endmodule

// File: tb/tb_rom_dl_packer.sv
// Directed bench for rom_dl_packer: expected Wishbone writes go into a queue and a
// monitor compares each transaction the DUT opens, plus its stability while stalled.
module tb_rom_dl_packer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [25:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [2:0]  wb_cti;
  logic        wb_ack = 1'b0;
  logic        active, done;

  rom_dl_packer dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_cti(wb_cti), .wb_ack(wb_ack),
    .active(active), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [25:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_lat  = 0;
  int   ack_cnt  = 0;
  int   done_cnt = 0;
  logic wait_seen = 1'b0;
  logic in_txn = 1'b0;
  txn_t cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [25:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    sb.push_back(txn_t'{adr, sel, dat});
  endtask

  // Slave: acknowledge after ack_lat stalled cycles.
  always @(negedge clk_sys) begin
    if (wb_cyc && wb_stb && !wb_ack) begin
      if (ack_cnt >= ack_lat) begin
        wb_ack  = 1'b1;
        ack_cnt = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      wb_ack  = 1'b0;
      ack_cnt = 0;
    end
  end

  // Monitor: compare each new transaction against the queue head, then hold it stable.
  always @(negedge clk_sys) begin
    if (wb_cyc) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        cur    = txn_t'{wb_adr, wb_sel, wb_dat_o};
        check("wb_stb", {63'b0, wb_stb}, 64'd1);
        check("wb_we", {63'b0, wb_we}, 64'd1);
        check("wb_cti", {61'b0, wb_cti}, 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_wb_cycle", {38'b0, wb_adr}, 64'hFFFF_FFFF);
        end else begin
          txn_t e;
          e = sb.pop_front();
          check("wb_adr", {38'b0, wb_adr}, {38'b0, e.adr});
          check("wb_sel", {60'b0, wb_sel}, {60'b0, e.sel});
          check("wb_dat", {32'b0, wb_dat_o}, {32'b0, e.dat});
        end
      end else begin
        check("wb_stable", {2'b0, wb_adr, wb_sel, wb_dat_o}, {2'b0, cur.adr, cur.sel, cur.dat});
      end
    end else begin
      in_txn = 1'b0;
    end
    if (done) done_cnt++;
    if (ioctl_wait) wait_seen = 1'b1;
  end

  task automatic hw_write(input logic [24:0] a, input logic [15:0] d);
    int g = 0;
    while (ioctl_wait && g < 200) begin
      @(negedge clk_sys);
      g++;
    end
    if (g >= 200) check("ioctl_wait_timeout", 64'd1, 64'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    @(negedge clk_sys);
  endtask

  task automatic end_dl_and_wait(input string name);
    int g = 0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check({name, "_wait_in_flush"}, {62'b0, ioctl_wait, active}, 64'd3);
    while (!done && g < 500) begin
      @(negedge clk_sys);
      g++;
    end
    check({name, "_done"}, {63'b0, done}, 64'd1);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    @(negedge clk_sys);
    check({name, "_idle"}, {61'b0, active, done, ioctl_wait}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    check("reset_outputs",
          {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, wb_cti, active, done, ioctl_wait},
          64'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("post_reset_idle", {61'b0, active, ioctl_wait, wb_cyc}, 64'd0);

    // Paired halfwords
    ack_lat = 0;
    expect_wr(26'h0400000, 4'b1111, 32'hABCD1234);
    start_dl(8'd1);
    check("active_in_load", {63'b0, active}, 64'd1);
    hw_write(25'd0, 16'h1234);
    hw_write(25'd2, 16'hABCD);
    end_dl_and_wait("paired");

    // Odd length: last low halfword flushed on its own
    expect_wr(26'h0400000, 4'b1111, 32'h00020001);
    expect_wr(26'h0400004, 4'b0011, 32'h00000003);
    start_dl(8'd1);
    hw_write(25'd0, 16'h0001);
    hw_write(25'd2, 16'h0002);
    hw_write(25'd4, 16'h0003);
    end_dl_and_wait("odd");

    // Slow slave with back-to-back halfwords
    ack_lat   = 5;
    wait_seen = 1'b0;
    for (int k = 0; k < 8; k++)
      expect_wr(26'h0400000 + 26'(4 * k), 4'b1111,
                {16'h1000 + 16'(2 * k + 1), 16'h1000 + 16'(2 * k)});
    start_dl(8'd1);
    for (int i = 0; i < 16; i++) hw_write(25'(2 * i), 16'h1000 + 16'(i));
    check("slow_wait_rose", {63'b0, wait_seen}, 64'd1);
    end_dl_and_wait("slow");

    // Wrong index: nothing happens
    ack_lat = 0;
    begin
      int d0;
      d0 = done_cnt;
      start_dl(8'd3);
      for (int i = 0; i < 4; i++) begin
        hw_write(25'(2 * i), 16'h7700 + 16'(i));
        check("wrongidx_quiet", {61'b0, active, ioctl_wait, wb_cyc}, 64'd0);
      end
      ioctl_download = 1'b0;
      repeat (5) @(negedge clk_sys);
      check("wrongidx_no_done", 64'(done_cnt - d0), 64'd0);
      check("wrongidx_no_cycle", {62'b0, wb_cyc, active}, 64'd0);
    end

    // Non-contiguous halfwords: double push
    expect_wr(26'h0400008, 4'b0011, 32'h00005555);
    expect_wr(26'h040000C, 4'b1100, 32'hAAAA0000);
    start_dl(8'd1);
    hw_write(25'd8, 16'h5555);
    hw_write(25'd14, 16'hAAAA);
    end_dl_and_wait("noncontig");

    // Mid-cycle asynchronous reset
    ack_lat = 20;
    expect_wr(26'h0400020, 4'b1111, 32'h22221111);
    start_dl(8'd1);
    hw_write(25'h20, 16'h1111);
    hw_write(25'h22, 16'h2222);
    begin
      int g = 0;
      while (!wb_stb && g < 50) begin
        @(negedge clk_sys);
        g++;
      end
      check("rst_stb_seen", {63'b0, wb_stb}, 64'd1);
    end
    #2;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("async_reset_outputs",
          {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, wb_cti, active, done, ioctl_wait},
          64'd0);
    sb.delete();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    ack_lat = 1;
    @(negedge clk_sys);
    check("rst_release_idle", {61'b0, active, ioctl_wait, wb_cyc}, 64'd0);
    expect_wr(26'h0400010, 4'b1111, 32'hCAFEBEEF);
    start_dl(8'd1);
    hw_write(25'h10, 16'hBEEF);
    hw_write(25'h12, 16'hCAFE);
    end_dl_and_wait("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
